// File: rtl/cpu_defs.sv
// Shared encodings for the accumulator CPU: FSM states, opcodes and ALU ops.
package cpu_defs;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

endpackage

// File: rtl/cu_decoder.sv
// Pure combinational opcode decode; the FSM decides when these take effect.
module cu_decoder
  import cpu_defs::*;
(
  input  logic [2:0] opcode_i,
  output logic       wr_o,
  output logic       wm_o,
  output logic [1:0] alu_op_o,
  output logic       jmp_o,
  output logic       jz_o,
  output logic       hlt_o
);

  // Map each opcode to its control strobes; unlisted strobes stay low.
  always_comb begin
    wr_o     = 1'b0;
    wm_o     = 1'b0;
    alu_op_o = ALU_PASS;
    jmp_o    = 1'b0;
    jz_o     = 1'b0;
    hlt_o    = 1'b0;
    case (opcode_i)
      OP_LDA: begin wr_o = 1'b1; alu_op_o = ALU_PASS; end
      OP_STA: wm_o = 1'b1;
      OP_ADD: begin wr_o = 1'b1; alu_op_o = ALU_ADD; end
      OP_SUB: begin wr_o = 1'b1; alu_op_o = ALU_SUB; end
      OP_AND: begin wr_o = 1'b1; alu_op_o = ALU_AND; end
      OP_JMP: jmp_o = 1'b1;
      OP_JZ:  jz_o  = 1'b1;
      default: hlt_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer owning PC and IR. Strobes are driven
// combinationally from the state register so an async reset kills them at once.
module cpu_control_unit
  import cpu_defs::*;
#(
  parameter int unsigned          ADDR_W   = 5,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              run_i,
  input  logic [7:0]        ins_i,
  input  logic [1:0]        flags_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [7:0]        ir_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wr_o,
  output logic              wm_o,
  output logic [1:0]        alu_op_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic              halted_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [ADDR_W-1:0] operand;

  logic       dec_wr, dec_wm, dec_jmp, dec_jz, dec_hlt;
  logic [1:0] dec_alu;

  // Only the zero flag steers control; carry is for the datapath.
  logic unused_carry;
  assign unused_carry = flags_i[1];

  assign operand = ADDR_W'(ir_q[4:0]);

  cu_decoder u_decoder (
    .opcode_i (ir_q[7:5]),
    .wr_o     (dec_wr),
    .wm_o     (dec_wm),
    .alu_op_o (dec_alu),
    .jmp_o    (dec_jmp),
    .jz_o     (dec_jz),
    .hlt_o    (dec_hlt)
  );

  // State, PC and IR registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic and per-state outputs; strobes only escape in EXEC.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    addr_o   = pc_q;
    wr_o     = 1'b0;
    wm_o     = 1'b0;
    alu_op_o = ALU_PASS;
    done_o   = 1'b0;
    halted_o = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (run_i) begin
          ir_d    = ins_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // PC advances even for HLT so the halted PC points past it.
        pc_d    = pc_q + ADDR_W'(1);
        state_d = dec_hlt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        addr_o   = operand;
        wr_o     = dec_wr;
        wm_o     = dec_wm;
        alu_op_o = dec_alu;
        done_o   = 1'b1;
        if (dec_jmp || (dec_jz && flags_i[0])) pc_d = operand;
        state_d  = ST_FETCH;
      end
      ST_HALT: halted_o = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  assign pc_o    = pc_q;
  assign ir_o    = ir_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: each task drives one scenario and
// checks hand-computed expectations inline.
module tb_cpu_control_unit;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       run_i;
  logic [7:0] ins_i;
  logic [1:0] flags_i;
  logic [4:0] pc_o, addr_o;
  logic [7:0] ir_o;
  logic       wr_o, wm_o, done_o, halted_o;
  logic [1:0] alu_op_o, state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  cpu_control_unit #(.ADDR_W(5), .RESET_PC(5'h00)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .run_i    (run_i),
    .ins_i    (ins_i),
    .flags_i  (flags_i),
    .pc_o     (pc_o),
    .ir_o     (ir_o),
    .addr_o   (addr_o),
    .wr_o     (wr_o),
    .wm_o     (wm_o),
    .alu_op_o (alu_op_o),
    .state_o  (state_o),
    .done_o   (done_o),
    .halted_o (halted_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one instruction in FETCH and advance to EXEC (or HALT).
  task automatic issue(input logic [7:0] ins, input logic [1:0] flags);
    run_i = 1'b1; ins_i = ins; flags_i = flags;
    tick();
    run_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; run_i = 1'b0; ins_i = 8'h00; flags_i = 2'b00;
    #3;
    n_cmp++;
    if ({state_o, pc_o, ir_o} !== {2'b00, 5'h00, 8'h00}) begin
      $display("FAIL reset_regs: got st=%b pc=%h ir=%h want st=00 pc=00 ir=00", state_o, pc_o, ir_o);
      n_fail++;
    end
    n_cmp++;
    if ({wr_o, wm_o, done_o, halted_o} !== 4'b0000) begin
      $display("FAIL reset_strobes: got wr,wm,done,halt=%b want 0000", {wr_o, wm_o, done_o, halted_o});
      n_fail++;
    end
    #4 reset_ni = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({state_o, pc_o} !== {2'b00, 5'h00}) begin
      $display("FAIL idle_after_reset: got st=%b pc=%h want st=00 pc=00", state_o, pc_o);
      n_fail++;
    end
  endtask

  task automatic test_lda();
    run_i = 1'b1; ins_i = 8'h03;
    tick();
    run_i = 1'b0;
    n_cmp++;
    if ({state_o, ir_o, pc_o} !== {2'b01, 8'h03, 5'h00}) begin
      $display("FAIL lda_decode: got st=%b ir=%h pc=%h want st=01 ir=03 pc=00", state_o, ir_o, pc_o);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({state_o, addr_o, wr_o, wm_o, alu_op_o, done_o, pc_o} !== {2'b10, 5'h03, 1'b1, 1'b0, 2'b00, 1'b1, 5'h01}) begin
      $display("FAIL lda_exec: got st=%b addr=%h wr=%b wm=%b alu=%b done=%b pc=%h want 10/03/1/0/00/1/01",
               state_o, addr_o, wr_o, wm_o, alu_op_o, done_o, pc_o);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({state_o, pc_o, addr_o, wr_o, done_o, alu_op_o} !== {2'b00, 5'h01, 5'h01, 1'b0, 1'b0, 2'b00}) begin
      $display("FAIL lda_retire: got st=%b pc=%h addr=%h wr=%b done=%b alu=%b want 00/01/01/0/0/00",
               state_o, pc_o, addr_o, wr_o, done_o, alu_op_o);
      n_fail++;
    end
  endtask

  task automatic test_sta();
    issue(8'h25, 2'b00);
    n_cmp++;
    if ({wm_o, wr_o, addr_o, pc_o} !== {1'b1, 1'b0, 5'h05, 5'h02}) begin
      $display("FAIL sta_exec: got wm=%b wr=%b addr=%h pc=%h want 1/0/05/02", wm_o, wr_o, addr_o, pc_o);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({wm_o, state_o, pc_o} !== {1'b0, 2'b00, 5'h02}) begin
      $display("FAIL sta_one_cycle: got wm=%b st=%b pc=%h want 0/00/02", wm_o, state_o, pc_o);
      n_fail++;
    end
  endtask

  task automatic test_jumps();
    issue(8'hAA, 2'b00);
    n_cmp++;
    if ({wr_o, wm_o, done_o} !== 3'b001) begin
      $display("FAIL jmp_strobes: got wr,wm,done=%b want 001", {wr_o, wm_o, done_o});
      n_fail++;
    end
    tick();
    n_cmp++;
    if (pc_o !== 5'h0A) begin
      $display("FAIL jmp_target: got pc=%h want 0a", pc_o);
      n_fail++;
    end
    issue(8'hC7, 2'b01);
    tick();
    n_cmp++;
    if (pc_o !== 5'h07) begin
      $display("FAIL jz_taken: got pc=%h want 07", pc_o);
      n_fail++;
    end
    issue(8'hC7, 2'b00);
    tick();
    n_cmp++;
    if (pc_o !== 5'h08) begin
      $display("FAIL jz_not_taken: got pc=%h want 08", pc_o);
      n_fail++;
    end
    issue(8'hC7, 2'b10);
    tick();
    n_cmp++;
    if (pc_o !== 5'h09) begin
      $display("FAIL jz_carry_only: got pc=%h want 09", pc_o);
      n_fail++;
    end
  endtask

  task automatic test_alu_ops();
    logic [7:0] ins [3];
    logic [1:0] op  [3];
    ins = '{8'h41, 8'h62, 8'h83};
    op  = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      issue(ins[i], 2'b00);
      n_cmp++;
      if ({wr_o, wm_o, alu_op_o, addr_o} !== {1'b1, 1'b0, op[i], ins[i][4:0]}) begin
        $display("FAIL alu_op_%0d: got wr=%b wm=%b alu=%b addr=%h want 1/0/%b/%h",
                 i, wr_o, wm_o, alu_op_o, addr_o, op[i], ins[i][4:0]);
        n_fail++;
      end
      tick();
    end
    n_cmp++;
    if (pc_o !== 5'h0C) begin
      $display("FAIL alu_pc: got pc=%h want 0c", pc_o);
      n_fail++;
    end
  endtask

  task automatic test_self_loop();
    for (int i = 0; i < 3; i++) begin
      issue(8'hAC, 2'b00);
      tick();
      n_cmp++;
      if ({state_o, pc_o} !== {2'b00, 5'h0C}) begin
        $display("FAIL self_loop_%0d: got st=%b pc=%h want 00/0c", i, state_o, pc_o);
        n_fail++;
      end
    end
  endtask

  task automatic test_stall();
    run_i = 1'b0; ins_i = 8'h5F;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({state_o, pc_o, ir_o} !== {2'b00, 5'h0C, 8'hAC}) begin
        $display("FAIL stall_%0d: got st=%b pc=%h ir=%h want 00/0c/ac", i, state_o, pc_o, ir_o);
        n_fail++;
      end
    end
  endtask

  task automatic test_wrap();
    issue(8'hBF, 2'b00);
    tick();
    issue(8'h01, 2'b00);
    n_cmp++;
    if ({state_o, pc_o} !== {2'b10, 5'h00}) begin
      $display("FAIL wrap_exec: got st=%b pc=%h want 10/00", state_o, pc_o);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({state_o, pc_o} !== {2'b00, 5'h00}) begin
      $display("FAIL wrap_fetch: got st=%b pc=%h want 00/00", state_o, pc_o);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_exec();
    issue(8'h44, 2'b00);
    n_cmp++;
    if ({wr_o, alu_op_o, pc_o} !== {1'b1, 2'b01, 5'h01}) begin
      $display("FAIL add_exec: got wr=%b alu=%b pc=%h want 1/01/01", wr_o, alu_op_o, pc_o);
      n_fail++;
    end
    #2 reset_ni = 1'b0;
    #1;
    n_cmp++;
    if ({wr_o, wm_o, done_o, alu_op_o, pc_o, state_o, ir_o} !== {1'b0, 1'b0, 1'b0, 2'b00, 5'h00, 2'b00, 8'h00}) begin
      $display("FAIL async_reset: got wr=%b wm=%b done=%b alu=%b pc=%h st=%b ir=%h want 0/0/0/00/00/00/00",
               wr_o, wm_o, done_o, alu_op_o, pc_o, state_o, ir_o);
      n_fail++;
    end
    #2 reset_ni = 1'b1;
    tick();
    n_cmp++;
    if ({state_o, pc_o} !== {2'b00, 5'h00}) begin
      $display("FAIL post_reset_idle: got st=%b pc=%h want 00/00", state_o, pc_o);
      n_fail++;
    end
  endtask

  task automatic test_halt();
    issue(8'hE0, 2'b01);
    n_cmp++;
    if ({state_o, halted_o, pc_o, done_o} !== {2'b11, 1'b1, 5'h01, 1'b0}) begin
      $display("FAIL halt_enter: got st=%b halted=%b pc=%h done=%b want 11/1/01/0", state_o, halted_o, pc_o, done_o);
      n_fail++;
    end
    run_i = 1'b1; ins_i = 8'h03;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({state_o, halted_o, wr_o, wm_o, done_o, pc_o} !== {2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 5'h01}) begin
        $display("FAIL halt_hold_%0d: got st=%b halted=%b wr=%b wm=%b done=%b pc=%h want 11/1/0/0/0/01",
                 i, state_o, halted_o, wr_o, wm_o, done_o, pc_o);
        n_fail++;
      end
    end
    run_i = 1'b0;
    #2 reset_ni = 1'b0;
    #1;
    n_cmp++;
    if ({halted_o, state_o} !== {1'b0, 2'b00}) begin
      $display("FAIL halt_reset: got halted=%b st=%b want 0/00", halted_o, state_o);
      n_fail++;
    end
    #2 reset_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sta();
    test_jumps();
    test_alu_ops();
    test_self_loop();
    test_stall();
    test_wrap();
    test_reset_mid_exec();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, program/data address width.
REQ-002 SHALL have parameter RESET_PC, default 5'h00, PC value loaded on reset.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port run_i, input, 1, start permission sampled in FETCH.
REQ-006 SHALL have port ins_i, input, 8, ROM data at pc_o; format opcode[7:5], operand address[4:0].
REQ-007 SHALL have port flags_i, input, 2, ALU status register {C,Z}.
REQ-008 SHALL have port pc_o, output, ADDR_W, current program counter.
REQ-009 SHALL have port ir_o, output, 8, instruction register.
REQ-010 SHALL have port addr_o, output, ADDR_W, RAM address.
REQ-011 SHALL have port wr_o, output, 1, accumulator write enable.
REQ-012 SHALL have port wm_o, output, 1, RAM write enable.
REQ-013 SHALL have port alu_op_o, output, 2, ALU op: 00 pass, 01 add, 10 sub, 11 and.
REQ-014 SHALL have port state_o, output, 2, FSM state encoding.
REQ-015 SHALL have port done_o, output, 1, one-cycle pulse at instruction retirement.
REQ-016 SHALL have port halted_o, output, 1, high while in HALT.

Function
REQ-017 SHALL implement FSM states FETCH=00, DECODE=01, EXEC=10, HALT=11.
REQ-018 In FETCH, when run_i=1, SHALL latch ins_i into IR and go to DECODE; when run_i=0, SHALL stay in FETCH with IR and PC unchanged.
REQ-019 In DECODE, SHALL increment PC modulo 2^ADDR_W (31 wraps to 0) and go to EXEC; opcode 111 (HLT) SHALL go to HALT instead, with PC still incremented.
REQ-020 In EXEC, addr_o SHALL equal IR[4:0]; in all other states addr_o SHALL equal pc_o.
REQ-021 EXEC decode: 000 LDA -> wr_o=1, alu_op=00; 001 STA -> wm_o=1; 010 ADD -> wr_o=1, alu_op=01; 011 SUB -> wr_o=1, alu_op=10; 100 AND -> wr_o=1, alu_op=11.
REQ-022 EXEC: 101 JMP SHALL load PC with IR[4:0]; 110 JZ SHALL load PC with IR[4:0] only if flags_i[0]=1 as sampled in EXEC, else PC is unchanged.
REQ-023 wr_o and wm_o SHALL be high only in EXEC, for exactly one cycle, never simultaneously.
REQ-024 alu_op_o SHALL be 00 outside EXEC.
REQ-025 done_o SHALL pulse during the EXEC cycle; EXEC SHALL always return to FETCH.
REQ-026 Non-HLT latency SHALL be 3 cycles from FETCH acceptance to the next FETCH.
REQ-027 HALT SHALL be terminal, with all write enables low, until reset.
REQ-028 A jump to the instruction's own address SHALL loop indefinitely without error.

Reset
REQ-029 reset_ni=0 SHALL immediately force state FETCH, PC=RESET_PC, IR=8'h00, with wr_o, wm_o, done_o and halted_o low, regardless of clock.
REQ-030 Reset asserted mid-EXEC SHALL suppress any pending wr_o/wm_o in the same instant; no partial write SHALL retire.
REQ-031 After reset release, the first FETCH SHALL occur at the first rising edge with run_i=1.

Structure
REQ-032 Opcode constants, ALU-op codes and state encodings SHALL live in a shared package/include (cpu_defs) used by cpu, ALU and benches.
REQ-033 Combinational decode SHALL be a sub-module, cu_decoder (opcode -> wr, wm, alu_op, jmp, jz, hlt); FSM and PC register stay in cpu_control_unit.

Verification
REQ-034 The bench SHALL cover: reset, run_i=1, ins_i=8'h03 (LDA 3) -> DECODE then EXEC with addr_o=03, wr_o=1, alu_op=00, done_o=1, pc_o=01.
REQ-035 The bench SHALL cover: ins_i=8'h25 (STA 5) -> wm_o=1 for one cycle in EXEC, addr_o=05, wr_o=0.
REQ-036 The bench SHALL cover: ins_i=8'hAA (JMP 10) -> pc_o=0A in the next FETCH; ins_i=8'hC7 (JZ 7) with flags_i=01 -> pc_o=07, with flags_i=00 -> pc_o=PC+1.
REQ-037 The bench SHALL cover: PC=1F executing non-jump -> pc_o=00 next FETCH; ins_i=8'hE0 (HLT) -> halted_o=1, state_o=11, held for 20 cycles.
REQ-038 The bench SHALL cover: run_i=0 in FETCH for 5 cycles -> state, PC and IR frozen.
REQ-039 The bench SHALL cover: reset_ni pulsed low between clock edges during EXEC of ADD -> wr_o drops immediately, pc_o=00, state_o=00.
